muldiv_unit: RTL and testbench

Iterative M-extension sequencer sitting beside the EX-stage ALU. It accepts a mul/div request (`aluc[0]=1` class), runs a 32-step shift-add multiply or restoring divide, and returns a 32-bit result. While it runs, it holds a stall to the pipeline so the requesting instruction stays in EX until the result is written back.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_step.sv | 19 +
 rtl/muldiv_unit.sv | 107 ++++++++++
 tb/tb_muldiv_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and constants for the M-extension sequencer
// Optional feature macro used by muldiv_unit: MULDIV_FAST_MUL_EN
package muldiv_pkg;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide
// Ports: is_div selects divide step; acc is the 64-bit working register; opnd is the
// multiplicand/divisor magnitude; nxt is the working register after this step.
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] nxt
);
    logic [32:0] sum;
    logic [33:0] diff;
    always_comb begin
        sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        // acc[63] is the bit shifted out of the partial remainder; keep it in the trial subtract
        diff = {1'b0, acc[63:31]} - {2'b0, opnd};
        nxt  = is_div ? (diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                      : {sum, acc[31:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide sequencer with pipeline stall
// Ports: clk, rst (async, active high); start/op/a/b request; kill flush;
// stall pipeline hold; busy FSM not idle; done one-cycle pulse; result value.
// Config: MULDIV_FAST_MUL_EN selects a single-cycle array multiplier for mul ops.
import muldiv_pkg::*;
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    muldiv_state_t state;
    logic [4:0]  cnt;
    logic [2:0]  op_r;
    logic [31:0] mb_r;
    logic        sgn;
    logic [63:0] acc;
    logic [63:0] nxt;
    logic        a_sgn, b_sgn, sa, sb, sign, special;
    logic [31:0] ma, mb, spec_val, fix_val, q, r;
    logic [63:0] p;
    muldiv_step u_step (
        .is_div (op_r[2]),
        .acc    (acc),
        .opnd   (mb_r),
        .nxt    (nxt)
    );
    always_comb begin
        a_sgn    = op[2] ? !op[0] : (op != OP_MULHU);
        b_sgn    = op[2] ? !op[0] : !op[1];
        sa       = a_sgn & a[31];
        sb       = b_sgn & b[31];
        ma       = sa ? -a : a;
        mb       = sb ? -b : b;
        // remainder follows the dividend; everything else is the xor of operand signs
        sign     = (op == OP_REM) ? sa : sa ^ sb;
        special  = op[2] & ((b == 32'd0) | (!op[0] & (a == INT_MIN) & (b == 32'hFFFF_FFFF)));
        spec_val = (b == 32'd0) ? (op[1] ? a : DIV0_QUOT) : (op[1] ? 32'd0 : INT_MIN);
        p        = sgn ? -acc : acc;
        q        = sgn ? -acc[31:0] : acc[31:0];
        r        = sgn ? -acc[63:32] : acc[63:32];
        fix_val  = op_r[2] ? (op_r[1] ? r : q) : (op_r == OP_MUL ? p[31:0] : p[63:32]);
        stall    = (start & (state == S_IDLE) & ~kill) | (state == S_CALC) | (state == S_FIX);
        busy     = state != S_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_r   <= '0;
            mb_r   <= '0;
            sgn    <= 1'b0;
            acc    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (kill) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_r <= op;
                    mb_r <= mb;
                    sgn  <= sign;
                    acc  <= {32'd0, ma};
                    cnt  <= 5'd31;
                    if (special) begin
                        result <= spec_val;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
                    acc <= op_r[2] ? nxt : 64'(acc[31:0]) * 64'(mb_r);
                    cnt <= cnt - 5'd1;
                    if (!op_r[2] || cnt == 5'd0) state <= S_FIX;
`else
                    acc <= nxt;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= S_FIX;
`endif
                end
                S_FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;
    int total = 0;
    int bad = 0;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 34;
`endif
    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // Issue one request, hold start through DONE, then drop it.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic st_ok;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        #1;
        st_ok = stall;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done !== 1'b1) st_ok &= stall;
        end
        check({tag, "_res"}, result, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall"}, {31'd0, st_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        @(negedge clk);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        start = 1'b0;
    endtask
    initial begin
        int ndone;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        do_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34);
        do_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34);
        do_op("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         1);
        do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        // kill in cycle 10 of a divide
        @(negedge clk);
        start = 1'b1;
        op = 3'b100;
        a = 32'd100;
        b = 32'd7;
        repeat (10) @(negedge clk);
        check("kill_busy_c10", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        start = 1'b0;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        repeat (40) begin
            ndone += int'(done);
            @(negedge clk);
        end
        check("kill_no_done", 32'(ndone), 32'd0);
        check("kill_result_held", result, 32'd0);
        do_op("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, MUL_LAT);
        // held start across DONE must not launch another operation
        ndone = 0;
        repeat (40) begin
            ndone += int'(done);
            @(negedge clk);
        end
        check("held_no_second", 32'(ndone), 32'd0);
        // reset in cycle 20 of a multiply
        @(negedge clk);
        start = 1'b1;
        op = 3'b011;
        a = 32'd9;
        b = 32'd9;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_result", result, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("mul_after_rst", 3'b000, 32'd6, 32'd5, 32'd30, MUL_LAT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
